// File: rtl/shift_rx.sv
// ---------------------------------------------------------------------------
// shift_rx : serial-to-parallel receiver with a one-word output slot.
//
// Bits arrive one per bit_valid/bit_ready transfer. They are assembled
// MSB-first (left shift) or LSB-first (right shift) into a WIDTH-bit word.
// The direction is sampled on the first bit of each word. A finished word
// goes straight to the output register when the slot is free or is being
// drained on the same edge. Otherwise the word is parked in the shift
// register, and the block stops accepting bits (HOLD) until the consumer
// takes the current output.
//
// Handshake rule used on both sides: a transfer happens on a rising clk edge
// where valid && ready. The producer holds data stable while valid is high
// and not yet accepted. ready may depend on state but never on valid.
//
// Ports
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous flush, highest priority
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid
//   bit_ready  out  block accepts a bit this cycle
//   dir        in   0 = MSB-first, 1 = LSB-first (sampled on first bit)
//   out        out  assembled word, stable while out_valid is high
//   out_valid  out  out holds an unconsumed word
//   out_ready  in   consumer takes the word
//   count      out  bits already accepted into the current word
//   state_dbg  out  FSM state for observation (0 = COLLECT, 1 = HOLD)
// ---------------------------------------------------------------------------
module shift_rx #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   output logic                     bit_ready,
   input  logic                     dir,
   output logic [WIDTH-1:0]         out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] count,
   output logic                     state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [CW-1:0]    cnt;
   logic             dir_q;
   logic             dir_use;
   logic             bit_xfer;
   logic             out_xfer;
   logic             word_done;
   logic             load_shift;   // finished word goes straight to out
   logic             load_held;    // parked word in sr moves to out
   logic             drop_valid;   // slot drained, nothing new arriving

   // ---------------- next-state and control ----------------
   always_comb begin
      bit_ready  = 1'b0;
      state_next = state;
      load_shift = 1'b0;
      load_held  = 1'b0;
      drop_valid = 1'b0;

      bit_ready = (state == COLLECT);
      bit_xfer  = bit_valid && bit_ready;
      out_xfer  = out_valid && out_ready;

      // The first bit of a word uses the live dir; the rest use the latch.
      dir_use   = (cnt == '0) ? dir : dir_q;
      sr_shift  = dir_use ? {bit_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bit_in};
      word_done = bit_xfer && (cnt == LAST);

      case (state)
         COLLECT: begin
            if (word_done) begin
               if (!out_valid || out_ready) begin
                  load_shift = 1'b1;
               end else begin
                  state_next = HOLD;
               end
            end else if (out_xfer) begin
               drop_valid = 1'b1;
            end
         end
         HOLD: begin
            // out_valid is always high here, so out_ready alone is a transfer.
            if (out_ready) begin
               load_held  = 1'b1;
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else if (clear) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         sr        <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (bit_xfer) begin
            sr  <= sr_shift;
            cnt <= word_done ? '0 : cnt + CW'(1);
            if (cnt == '0) begin
               dir_q <= dir;
            end
         end

         if (load_shift) begin
            out       <= sr_shift;
            out_valid <= 1'b1;
         end else if (load_held) begin
            out       <= sr;
            out_valid <= 1'b1;
         end else if (drop_valid) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign count     = cnt;
   assign state_dbg = (state == HOLD);

endmodule

// File: tb/tb_shift_rx.sv
// ---------------------------------------------------------------------------
// tb_shift_rx : self-checking bench for shift_rx (WIDTH = 8).
//
// The reference model keeps the bits of the current word in a queue, along
// with the word in the output slot and an optional parked word. A finished
// word is built by placing each queued bit at its index: MSB-first puts the
// first bit at the top, LSB-first puts it at the bottom. Words handed to the
// output slot are also pushed to exp_q and are popped when the DUT drains
// them.
// Inputs are driven right after a falling edge. Outputs are checked on the
// falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_shift_rx;

   localparam int W  = 8;
   localparam int CW = $clog2(W);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          clear = 1'b0;
   logic          bit_in = 1'b0;
   logic          bit_valid = 1'b0;
   logic          bit_ready;
   logic          dir = 1'b0;
   logic [W-1:0]  out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] count;
   logic          state_dbg;

   shift_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .dir       (dir),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .state_dbg (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   logic         m_bits[$];
   logic         m_dir;
   logic [W-1:0] m_out;
   logic         m_outv;
   logic [W-1:0] m_held;
   logic         m_heldv;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] build_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) begin
         if (m_dir) w[i] = m_bits[i];
         else       w[W-1-i] = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_dir   = 1'b0;
      m_out   = '0;
      m_outv  = 1'b0;
      m_held  = '0;
      m_heldv = 1'b0;
      exp_q.delete();
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic bv, input logic b, input logic d,
                             input logic ordy, input logic clr);
      logic [W-1:0] w;
      if (clr) begin
         model_reset();
         return;
      end
      if (m_heldv) begin
         if (ordy) begin
            m_out   = m_held;
            m_heldv = 1'b0;
            m_outv  = 1'b1;
            exp_q.push_back(m_held);
         end
         return;
      end
      if (bv) begin
         if (m_bits.size() == 0) m_dir = d;
         m_bits.push_back(b);
         if (m_bits.size() == W) begin
            w = build_word();
            m_bits.delete();
            if (!m_outv || ordy) begin
               m_out  = w;
               m_outv = 1'b1;
               exp_q.push_back(w);
            end else begin
               m_held  = w;
               m_heldv = 1'b1;
            end
            return;
         end
      end
      if (m_outv && ordy) m_outv = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".bit_ready"}, 32'(bit_ready), 32'(!m_heldv));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_outv));
      chk({tag, ".out"},       32'(out),       32'(m_out));
      chk({tag, ".count"},     32'(count),     32'(m_bits.size()));
      chk({tag, ".state"},     32'(state_dbg), 32'(m_heldv));
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic bv, input logic b, input logic d,
                       input logic ordy, input logic clr, input string tag);
      logic [W-1:0] e;
      bit_valid = bv;
      bit_in    = b;
      dir       = d;
      out_ready = ordy;
      clear     = clr;
      #1;
      if (out_valid && out_ready && !clr) begin
         if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(1), 32'(0));
         end else begin
            e = exp_q.pop_front();
            chk({tag, ".sb_word"}, 32'(out), 32'(e));
         end
      end
      @(posedge clk);
      model_edge(bv, b, d, ordy, clr);
      @(negedge clk);
      chk_model(tag);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic d,
                            input logic ordy, input string tag);
      for (int i = 0; i < W; i++) begin
         step(1'b1, d ? w[i] : w[W-1-i], d, ordy, 1'b0, tag);
      end
   endtask

   task automatic pulse_reset(input string tag);
      rst_n     = 1'b0;
      bit_valid = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      #1;
      model_reset();
      chk({tag, ".rst_count"},     32'(count),     32'(0));
      chk({tag, ".rst_out_valid"}, 32'(out_valid), 32'(0));
      chk({tag, ".rst_out"},       32'(out),       32'(0));
      chk({tag, ".rst_bit_ready"}, 32'(bit_ready), 32'(1));
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      model_reset();
      @(negedge clk);
      pulse_reset("reset");
      chk_model("post_reset");

      // MSB-first 1,0,1,0,... -> 0xAA
      send_word(8'hAA, 1'b0, 1'b1, "msb");
      chk("msb.word",  32'(out),       32'h0000_00AA);
      chk("msb.valid", 32'(out_valid), 32'(1));
      chk("msb.count", 32'(count),     32'(0));

      // LSB-first 0,1,0,1,... with dir toggling after the first bit
      for (int i = 0; i < W; i++) begin
         step(1'b1, logic'(i % 2), (i == 0) ? 1'b1 : logic'(i % 2), 1'b1, 1'b0, "lsb");
      end
      chk("lsb.word", 32'(out), 32'h0000_00AA);

      // Backpressure: 0x3C then 0xC3 with the slot blocked
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain0");
      send_word(8'h3C, 1'b0, 1'b0, "bp1");
      send_word(8'hC3, 1'b0, 1'b0, "bp2");
      chk("bp.hold_ready", 32'(bit_ready), 32'(0));
      chk("bp.hold_out",   32'(out),       32'h0000_003C);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bp_rel1");
      chk("bp.second_out", 32'(out),       32'h0000_00C3);
      chk("bp.ready_back", 32'(bit_ready), 32'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bp_rel2");
      chk("bp.drained",    32'(out_valid), 32'(0));
      chk("bp.out_kept",   32'(out),       32'h0000_00C3);

      // Streaming 0x12 0x34 0x56 with out_ready held high
      send_word(8'h12, 1'b0, 1'b1, "s12");
      chk("stream.12", 32'(out), 32'h0000_0012);
      send_word(8'h34, 1'b0, 1'b1, "s34");
      chk("stream.34", 32'(out), 32'h0000_0034);
      send_word(8'h56, 1'b0, 1'b1, "s56");
      chk("stream.56", 32'(out), 32'h0000_0056);
      chk("stream.ready", 32'(bit_ready), 32'(1));

      // Reset mid-word, then 0xFF
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "partial_r");
      pulse_reset("midreset");
      send_word(8'hFF, 1'b0, 1'b1, "ff_r");
      chk("midreset.word", 32'(out), 32'h0000_00FF);

      // Clear mid-word, then 0xFF
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "partial_c");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "clear");
      chk("clear.count", 32'(count),     32'(0));
      chk("clear.valid", 32'(out_valid), 32'(0));
      chk("clear.out",   32'(out),       32'(0));
      send_word(8'hFF, 1'b0, 1'b1, "ff_c");
      chk("clear.word", 32'(out), 32'h0000_00FF);

      // Completion and drain on the same edge
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain1");
      send_word(8'h5A, 1'b0, 1'b0, "sim1");
      for (int i = 0; i < W; i++) begin
         step(1'b1, logic'((8'hA5 >> (W-1-i)) & 1), 1'b0, (i == W-1), 1'b0, "sim2");
      end
      chk("simul.word",  32'(out),       32'h0000_00A5);
      chk("simul.valid", 32'(out_valid), 32'(1));
      chk("simul.state", 32'(state_dbg), 32'(0));

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 99) == 0), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
